// File: rtl/decode_issue_buffer_pkg.sv
// Shared micro-op layout for the decode/execute boundary: field offsets, widths
// and control-bit positions used to pack UopD and unpack UopE.
package decode_issue_buffer_pkg;
    localparam int WORD_SIZE_DEF = 32;
    localparam int CTRL_W_DEF    = 14;
    localparam int REG_W         = 5;

    // Control field bit positions (LSB-relative within ctrl), MSB first.
    localparam int CTRL_REGWRITE     = 13;
    localparam int CTRL_MEMWRITE     = 12;
    localparam int CTRL_JUMP         = 11;
    localparam int CTRL_BRANCH       = 10;
    localparam int CTRL_ALUSRC       = 9;
    localparam int CTRL_RESULTSRC_LO = 7;
    localparam int CTRL_ALUCTRL_LO   = 4;
    localparam int CTRL_TAKINGBRANCH = 3;
    localparam int CTRL_BYTEADDRESS  = 2;
    localparam int CTRL_READENABLE   = 1;
    localparam int CTRL_SPARE        = 0;

    function automatic int uop_w(input int ws, input int cw);
        return 5 * ws + 3 * REG_W + cw;
    endfunction

    function automatic int off_rd(input int cw);
        return cw;
    endfunction

    function automatic int off_rs2(input int cw);
        return cw + REG_W;
    endfunction

    function automatic int off_rs1(input int cw);
        return cw + 2 * REG_W;
    endfunction

    function automatic int off_imm(input int cw);
        return cw + 3 * REG_W;
    endfunction

    function automatic int off_pcp4(input int ws, input int cw);
        return off_imm(cw) + ws;
    endfunction

    function automatic int off_pc(input int ws, input int cw);
        return off_imm(cw) + 2 * ws;
    endfunction

    function automatic int off_rd2(input int ws, input int cw);
        return off_imm(cw) + 3 * ws;
    endfunction

    function automatic int off_rd1(input int ws, input int cw);
        return off_imm(cw) + 4 * ws;
    endfunction
endpackage

// File: rtl/decode_issue_buffer_uop_operand_patch.sv
// Replaces RD1/RD2 of a micro-op with the writeback result when the writeback
// destination matches Rs1/Rs2; x0 is never forwarded.
module uop_operand_patch
    import decode_issue_buffer_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int CTRL_W    = CTRL_W_DEF,
    localparam int UOP_W    = uop_w(WORD_SIZE, CTRL_W)
) (
    input  logic [UOP_W-1:0]     uop_i,
    input  logic                 reg_write_i,
    input  logic [REG_W-1:0]     rd_i,
    input  logic [WORD_SIZE-1:0] result_i,
    output logic [UOP_W-1:0]     uop_o
);
    localparam int OFF_RS1 = off_rs1(CTRL_W);
    localparam int OFF_RS2 = off_rs2(CTRL_W);
    localparam int OFF_RD1 = off_rd1(WORD_SIZE, CTRL_W);
    localparam int OFF_RD2 = off_rd2(WORD_SIZE, CTRL_W);

    logic wb_live;

    always_comb begin
        wb_live = reg_write_i && (rd_i != '0);
        uop_o   = uop_i;
        if (wb_live && (rd_i == uop_i[OFF_RS1 +: REG_W])) begin
            uop_o[OFF_RD1 +: WORD_SIZE] = result_i;
        end
        if (wb_live && (rd_i == uop_i[OFF_RS2 +: REG_W])) begin
            uop_o[OFF_RD2 +: WORD_SIZE] = result_i;
        end
    end
endmodule

// File: rtl/decode_issue_buffer.sv
// DEPTH-entry FIFO of decoded micro-ops between decode and execute, with
// per-entry valid bits, synchronous flush and writeback patching of operands.
module decode_issue_buffer
    import decode_issue_buffer_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int DEPTH     = 2,
    parameter int CTRL_W    = CTRL_W_DEF,
    localparam int UOP_W    = uop_w(WORD_SIZE, CTRL_W),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ValidD,
    output logic                 ReadyD,
    input  logic [UOP_W-1:0]     UopD,
    output logic                 ValidE,
    input  logic                 ReadyE,
    output logic [UOP_W-1:0]     UopE,
    input  logic                 FlushE,
    input  logic                 RegWriteW,
    input  logic [REG_W-1:0]     RdW,
    input  logic [WORD_SIZE-1:0] ResultW,
    output logic [CNT_W-1:0]     Count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [UOP_W-1:0] mem_q [DEPTH];
    logic [UOP_W-1:0] mem_d [DEPTH];
    logic [UOP_W-1:0] mem_patched [DEPTH];
    logic [UOP_W-1:0] uop_in_patched;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry_patch
        uop_operand_patch #(.WORD_SIZE(WORD_SIZE), .CTRL_W(CTRL_W)) u_patch (
            .uop_i      (mem_q[g]),
            .reg_write_i(RegWriteW),
            .rd_i       (RdW),
            .result_i   (ResultW),
            .uop_o      (mem_patched[g])
        );
    end

    uop_operand_patch #(.WORD_SIZE(WORD_SIZE), .CTRL_W(CTRL_W)) u_in_patch (
        .uop_i      (UopD),
        .reg_write_i(RegWriteW),
        .rd_i       (RdW),
        .result_i   (ResultW),
        .uop_o      (uop_in_patched)
    );

    assign ReadyD = (count_q < CNT_W'(DEPTH)) || ReadyE;
    assign ValidE = valid_q[head_q];
    assign UopE   = mem_q[head_q];
    assign Count  = count_q;
    assign push   = ValidD && ReadyD;
    assign pop    = ValidE && ReadyE;

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) mem_d[i] = mem_patched[i];
        end
        if (FlushE) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pop clears first so a full push+pop can reuse the freed head slot.
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = ptr_inc(head_q);
            end
            if (push) begin
                valid_d[tail_q] = 1'b1;
                mem_d[tail_q]   = uop_in_patched;
                tail_d          = ptr_inc(tail_q);
            end
            if (push && !pop) count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: doc/decode_issue_buffer.md
Name: decode_issue_buffer

Overview:
- Parametrised successor to the single-entry ID/EX pipeline register.
- A DEPTH-entry FIFO of fully decoded micro-ops sits between the decode stage and the execute stage, with a valid/ready handshake.
- Each entry carries an explicit valid bit, so flush inserts true bubbles instead of zeroed control fields.
- Buffered operands are patched from the writeback port while they wait, so stalled entries never carry stale register values.

Parameters:
- WORD_SIZE, 32, datapath width of the RD1, RD2, PC, PCPlus4 and ImmExt fields.
- DEPTH, 2, number of entries. Legal values are 1 to 8.
- CTRL_W, 14, width of the packed control field: RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0], TakingBranch, ByteAddress, ReadEnable, spare.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ValidD  in  1  decode presents a micro-op this cycle.
- ReadyD  out  1  buffer can accept. Equals (count < DEPTH) or ReadyE.
- UopD  in  UOP_W  packed micro-op. Field order from MSB: RD1, RD2, PC, PCPlus4, ImmExt, Rs1, Rs2, Rd, ctrl. UOP_W = 5*WORD_SIZE + 15 + CTRL_W.
- ValidE  out  1  head entry is valid.
- ReadyE  in  1  execute consumes the head. This is the inverse of StallE.
- UopE  out  UOP_W  head micro-op, driven from a register.
- FlushE  in  1  discard all entries.
- RegWriteW  in  1  writeback enable.
- RdW  in  5  writeback destination register.
- ResultW  in  WORD_SIZE  writeback data.
- Count  out  clog2(DEPTH+1)  occupancy, for debug and hazard logic.

Behaviour:
- Reset: all valid bits cleared, head and tail pointers at 0, Count=0, ValidE=0, UopE=0. ReadyD=1 once reset deasserts.
- Push: occurs on a clock edge when ValidD & ReadyD. Pop: occurs when ValidE & ReadyE.
- Minimum latency is 1 cycle. There is no combinational path from UopD to UopE.
- Throughput is 1 micro-op per cycle when ReadyE is held high.
- Simultaneous push and pop when full is legal. Count is unchanged and the tail takes the freed slot.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- FlushE is synchronous and has priority over push and pop in the same cycle. After the edge, Count=0, ValidE=0, and the incoming UopD is dropped.
- Reset asserted mid-operation clears state asynchronously, regardless of FlushE or the handshake.
- Writeback patch, applied to every valid stored entry each cycle:
  - Condition: RegWriteW, RdW≠0, and RdW==Rs1 → RD1 ← ResultW.
  - Same rule for Rs2 → RD2.
  - The same patch is applied to UopD on the cycle it is captured.
  - Rd=x0 is never patched.
- UopE is undefined (held at its last value) while ValidE=0. Consumers must qualify it with ValidE.
- Count never exceeds DEPTH. Push when ReadyD=0 is ignored; the upstream stage holds UopD.

Decomposition:
- Shared constants header: WORD_SIZE, UOP field offsets and widths, CTRL bit positions, and UOP_W.
- Decode and execute stages use the same offsets to pack and unpack UopD/UopE.
- One sub-module, uop_operand_patch: combinational compare-and-replace of RD1/RD2 against the writeback port. It is instantiated per entry plus once on the input.

Test Plan:
1. Reset, then DEPTH=2, ReadyE=1, push PC=0x00, 0x04, 0x08 back-to-back → ValidE asserts one cycle after each push, UopE.PC = 0x00, 0x04, 0x08 on consecutive cycles, and Count stays ≤1.
2. ReadyE=0, push 3 micro-ops → Count=2 after two edges, ReadyD=0, third UopD not accepted. Release ReadyE → entries drain in order, then the third is accepted.
3. Full buffer, ValidD=1 and ReadyE=1 in the same cycle → Count stays 2, head advances, new tail holds the pushed PC.
4. Buffer holds Rs1=5, RD1=0x11, stalled. Apply RegWriteW=1, RdW=5, ResultW=0xDEAD → next edge gives RD1=0xDEAD. Repeat with RdW=0 → no change.
5. Count=2, FlushE=1 with ValidD=1 → next edge Count=0, ValidE=0, pushed micro-op absent, ReadyD=1.
6. Assert rst while Count=1 and between edges → ValidE=0 and Count=0 immediately, with no clock edge required.
